// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM responder and its storage array.
package mem_pkg;

  localparam int MEM_WORD_W      = 32;
  localparam int MEM_MASK_W      = 4;
  localparam int MEM_CNT_W       = 4;
  localparam int MEM_DEPTH_DEF   = 1024;
  localparam int MEM_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/sram_array.sv
// DEPTH x 32 storage: one synchronous byte-enabled write port, one asynchronous read port.
module sram_array
  import mem_pkg::*;
#(
  parameter  int DEPTH  = MEM_DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [MEM_MASK_W-1:0] wmask_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [MEM_WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [MEM_WORD_W-1:0] rdata_o
);

  logic [MEM_WORD_W-1:0] mem_q [DEPTH];

  // NOTE: storage deliberately has no reset; its contents survive reset_n and
  // a reset branch here would prevent the array from mapping onto RAM.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int i = 0; i < MEM_MASK_W; i++) begin
        if (wmask_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sram_responder.sv
// Single-outstanding SRAM responder: IDLE/WAIT/RESP FSM, latency counter, range check.
module sram_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = MEM_DEPTH_DEF,
  parameter int LATENCY = MEM_LATENCY_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  reqValid,
  input  logic                  reqWen,
  input  logic [31:0]           reqAddr,
  input  logic [MEM_WORD_W-1:0] reqWdata,
  input  logic [MEM_MASK_W-1:0] reqWmask,
  output logic                  respValid,
  output logic [MEM_WORD_W-1:0] respRdata,
  output logic                  respErr,
  output logic                  busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [MEM_CNT_W-1:0] CNT_LOAD = MEM_CNT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [MEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [MEM_WORD_W-1:0] hold_q, hold_d;

  logic                  accept;
  logic                  req_oor;
  logic [ADDR_W-1:0]     req_idx;
  logic [MEM_WORD_W-1:0] mem_rdata;
  logic                  unused_bits;

  assign req_idx     = reqAddr[ADDR_W+1:2];
  assign req_oor     = |reqAddr[31:ADDR_W+2];
  assign accept      = (state_q == IDLE) && reqValid;
  // Byte offset is ignored; the latched index is kept for observability only.
  assign unused_bits = ^{reqAddr[1:0], idx_q};

  sram_array #(.DEPTH(DEPTH)) u_array (
    .clock   (clock),
    .we_i    (accept && reqWen && !req_oor),
    .wmask_i (reqWmask),
    .waddr_i (req_idx),
    .wdata_i (reqWdata),
    .raddr_i (req_idx),
    .rdata_o (mem_rdata)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    err_d   = err_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          wen_d   = reqWen;
          idx_d   = req_idx;
          err_d   = req_oor;
          cnt_d   = CNT_LOAD;
          hold_d  = (reqWen || req_oor) ? '0 : mem_rdata;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // Counter parks at 1 and is only reloaded on the next accept.
        if (cnt_q <= MEM_CNT_W'(1)) state_d = RESP;
        else                        cnt_d   = cnt_q - MEM_CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign respValid = (state_q == RESP);
  assign respErr   = (state_q == RESP) && err_q;
  assign respRdata = ((state_q == RESP) && !wen_q && !err_q) ? hold_q : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_responder.sv
// Randomised self-checking bench: three responders (LATENCY 1..3) against a word-array model.
module tb_sram_responder;

  localparam int DEPTH = 1024;
  localparam int NINST = 3;

  logic        clk = 1'b0;
  logic        rst_n      [NINST];
  logic        req_valid  [NINST];
  logic        req_wen    [NINST];
  logic [31:0] req_addr   [NINST];
  logic [31:0] req_wdata  [NINST];
  logic [3:0]  req_wmask  [NINST];
  logic        resp_valid [NINST];
  logic [31:0] resp_rdata [NINST];
  logic        resp_err   [NINST];
  logic        busy       [NINST];

  logic [31:0] mdl_mem [NINST][DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  int pool [16] = '{0, 1, 2, 3, 16, 17, 32, 33, 64, 128, 255, 256, 511, 512, 1000, 1023};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    sram_responder #(.DEPTH(DEPTH), .LATENCY(g + 1)) u_dut (
      .clock     (clk),
      .reset_n   (rst_n[g]),
      .reqValid  (req_valid[g]),
      .reqWen    (req_wen[g]),
      .reqAddr   (req_addr[g]),
      .reqWdata  (req_wdata[g]),
      .reqWmask  (req_wmask[g]),
      .respValid (resp_valid[g]),
      .respRdata (resp_rdata[g]),
      .respErr   (resp_err[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] mask);
    logic [31:0] res = old;
    for (int i = 0; i < 4; i++) if (mask[i]) res[8*i +: 8] = data[8*i +: 8];
    return res;
  endfunction

  function automatic bit is_oor(input logic [31:0] addr);
    return addr >= 32'(DEPTH * 4);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  // Model step for an accepted request; returns the response data it must produce.
  function automatic logic [31:0] model_accept(input int k, input bit wen, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] mask);
    if (is_oor(addr)) return 32'h0;
    if (wen) begin
      mdl_mem[k][word_of(addr)] = merge(mdl_mem[k][word_of(addr)], wdata, mask);
      return 32'h0;
    end
    return mdl_mem[k][word_of(addr)];
  endfunction

  task automatic drive(input int k, input bit v, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    req_valid[k] = v;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = mask;
  endtask

  // One full transaction on instance k; 'noise' strobes ignored requests while busy.
  task automatic do_req(input int k, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input bit noise, output logic [31:0] rd);
    logic [31:0] e_data;
    bit          e_err;
    bit          got = 0;
    @(negedge clk);
    check("idle_before_req", 64'(busy[k]), 64'(0));
    e_err  = is_oor(addr);
    e_data = model_accept(k, wen, addr, wdata, mask);
    drive(k, 1'b1, wen, addr, wdata, mask);
    @(negedge clk);
    req_valid[k] = 1'b0;
    rd = 32'hx;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (resp_valid[k]) begin
        got = 1;
        rd  = resp_rdata[k];
        check("latency", 64'(c), 64'(k + 1));
        check("resp_rdata", 64'(resp_rdata[k]), 64'(e_data));
        check("resp_err", 64'(resp_err[k]), 64'(e_err));
      end else begin
        check("wait_outputs", {busy[k], resp_err[k], resp_rdata[k]}, {1'b1, 1'b0, 32'h0});
        if (noise && $urandom_range(1, 0) == 1)
          drive(k, 1'b1, 1'b1, 32'(pool[$urandom_range(15, 0)] * 4), $urandom, 4'hF);
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
    end
    if (!got) check("resp_timeout", 64'(0), 64'(1));
    check("single_pulse", {resp_valid[k], busy[k]}, 64'(0));
  endtask

  // Accept a request, then reset while in WAIT; no response may ever follow.
  task automatic abort_req(input int k, input bit wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    logic [31:0] unused_rd;
    @(negedge clk);
    unused_rd = model_accept(k, wen, addr, wdata, mask);
    drive(k, 1'b1, wen, addr, wdata, mask);
    @(negedge clk);
    req_valid[k] = 1'b0;
    check("busy_in_wait", 64'(busy[k]), 64'(1));
    rst_n[k] = 1'b0;
    #1;
    check("rst_async", {busy[k], resp_valid[k], resp_rdata[k]}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n[k] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_resp_after_rst", {resp_valid[k], busy[k]}, 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          exp_busy  [10];
    bit          exp_valid [10];
    logic [31:0] seq_data;
    int          t;

    for (int k = 0; k < NINST; k++) begin
      rst_n[k] = 1'b0;
      drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NINST; k++)
      check("reset_outputs", {resp_valid[k], resp_err[k], busy[k], resp_rdata[k]}, 64'(0));
    for (int k = 0; k < NINST; k++) rst_n[k] = 1'b1;

    for (int k = 0; k < NINST; k++)
      foreach (pool[i]) do_req(k, 1'b1, 32'(pool[i] * 4), $urandom, 4'hF, 1'b0, rd);

    // Full-word write then read-back at LATENCY=2.
    do_req(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b0, rd);
    do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd);
    check("rd_0x40", 64'(rd), 64'(32'h1234_5678));

    // Byte-lane merge and an empty-mask write.
    do_req(1, 1'b1, 32'h80, 32'hAABB_CCDD, 4'hF, 1'b0, rd);
    do_req(1, 1'b1, 32'h80, 32'h0000_EE00, 4'b0010, 1'b0, rd);
    do_req(1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, rd);
    check("lane_merge", 64'(rd), 64'(32'hAABB_EEDD));
    do_req(1, 1'b1, 32'h80, 32'h5555_5555, 4'b0000, 1'b0, rd);
    do_req(1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, rd);
    check("mask_zero", 64'(rd), 64'(32'hAABB_EEDD));

    // Out-of-range read and suppressed write.
    do_req(1, 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 1'b0, rd);
    do_req(1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, rd);
    do_req(1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd);
    check("oor_write_suppressed", 64'(rd), 64'(32'h0BAD_F00D));

    // reqValid held for 5 cycles at LATENCY=3: expected timeline from the period rule.
    foreach (exp_busy[n]) begin exp_busy[n] = 0; exp_valid[n] = 0; end
    t = 0;
    while (t < 5) begin
      for (int j = 1; j <= 3; j++) if (t + j < 10) exp_busy[t + j] = 1;
      if (t + 3 < 10) exp_valid[t + 3] = 1;
      t = t + 3 + 1;
    end
    seq_data = mdl_mem[2][64];
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("hold_busy_c%0d", n), 64'(busy[2]), 64'(exp_busy[n]));
      check($sformatf("hold_valid_c%0d", n), 64'(resp_valid[2]), 64'(exp_valid[n]));
      if (exp_valid[n]) check($sformatf("hold_rdata_c%0d", n), 64'(resp_rdata[2]), 64'(seq_data));
      @(negedge clk);
      if (n + 1 == 5) req_valid[2] = 1'b0;
    end

    // Reset during WAIT: read abort, write abort (write stays applied), then read back.
    abort_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    abort_req(1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
    do_req(1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, rd);
    check("rd_after_abort", 64'(rd), 64'(32'hDEAD_BEEF));
    abort_req(2, 1'b0, 32'h400, 32'h0, 4'h0);
    do_req(2, 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, rd);

    // LATENCY=1 back-to-back reads; the strobe in RESP must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("l1_c1_valid", 64'(resp_valid[0]), 64'(1));
    check("l1_c1_rdata", 64'(resp_rdata[0]), 64'(mdl_mem[0][0]));
    req_addr[0] = 32'h4;
    @(negedge clk);
    check("l1_c2_idle", {resp_valid[0], busy[0]}, 64'(0));
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("l1_c3_valid", 64'(resp_valid[0]), 64'(1));
    check("l1_c3_rdata", 64'(resp_rdata[0]), 64'(mdl_mem[0][1]));
    @(negedge clk);
    check("l1_c4_idle", {resp_valid[0], busy[0]}, 64'(0));

    // Random traffic across all three latencies.
    for (int i = 0; i < 300; i++) begin
      int          k    = $urandom_range(NINST - 1, 0);
      logic [31:0] addr;
      if ($urandom_range(7, 0) == 0) addr = $urandom | 32'h0000_1000;
      else addr = 32'(pool[$urandom_range(15, 0)] * 4) + 32'($urandom_range(3, 0));
      do_req(k, 1'($urandom_range(1, 0)), addr, $urandom, 4'($urandom_range(15, 0)), 1'b1, rd);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
